// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// serial_pkg : shared data width, default sizing and read-FSM states.
// Revision 1.0
// ============================================================================
package serial_pkg;

  localparam int DATA_W    = 8;
  localparam int DEPTH_DEF = 16;
  localparam int HI_WM_DEF = 12;
  localparam int LO_WM_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_GAP  = 2'd2
  } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/serial_sync2.sv
`default_nettype none
// ============================================================================
// serial_sync2 : two-flop synchronizer for a single asynchronous level input.
// Revision 1.0
// ============================================================================
module serial_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/serial_rx_fifo.sv
`default_nettype none
// ============================================================================
// serial_rx_fifo : UART receive FIFO with RTS/CTS flow control and paced TX handoff.
// Revision 1.0
// ============================================================================
module serial_rx_fifo
  import serial_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int HI_WM = HI_WM_DEF,
  parameter int LO_WM = LO_WM_DEF
) (
  input  logic                     CLK_100_I,
  input  logic                     RSTN_I,
  input  logic [DATA_W-1:0]        BYTE_I,
  input  logic                     RDY_I,
  input  logic                     RTS_I,
  input  logic                     TX_BUSY_I,
  output logic [DATA_W-1:0]        BYTE_O,
  output logic                     RDY_O,
  output logic                     CTS_O,
  output logic [$clog2(DEPTH):0]   COUNT_O,
  output logic                     OVF_O
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] HI_C    = CW'(HI_WM);
  localparam logic [CW-1:0] LO_C    = CW'(LO_WM);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic              ovf_q;
  logic              cts_q;
  rd_state_e         state_q;
  logic [DATA_W-1:0] byte_q;
  logic              rdy_q;

  logic rts_s;
  logic full;
  logic empty;
  logic pop;
  logic push_ok;
  logic drop;

  serial_sync2 u_rts_sync (
    .clk_i  (CLK_100_I),
    .rst_ni (RSTN_I),
    .d_i    (RTS_I),
    .q_o    (rts_s)
  );

  // A pop frees a slot on the same edge, so a push into a full FIFO is kept then.
  always_comb begin
    full    = (count_q == DEPTH_C);
    empty   = (count_q == '0);
    pop     = (state_q == ST_IDLE) && !empty && rts_s && !TX_BUSY_I;
    push_ok = RDY_I && (!full || pop);
    drop    = RDY_I && full && !pop;
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge CLK_100_I) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= BYTE_I;
    end
  end

  always_ff @(posedge CLK_100_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      cts_q    <= 1'b1;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
      if (drop) begin
        ovf_q <= 1'b1;
      end
      if (count_d >= HI_C) begin
        cts_q <= 1'b0;
      end else if (count_d <= LO_C) begin
        cts_q <= 1'b1;
      end
    end
  end

  // Once a byte is popped it is always strobed out; rts_s only gates new pops.
  always_ff @(posedge CLK_100_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      state_q <= ST_IDLE;
      byte_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            state_q <= ST_LOAD;
            byte_q  <= mem_q[rd_ptr_q];
            rdy_q   <= 1'b1;
          end
        end
        ST_LOAD: begin
          state_q <= ST_GAP;
        end
        ST_GAP: begin
          if (!TX_BUSY_I) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign BYTE_O  = byte_q;
  assign RDY_O   = rdy_q;
  assign CTS_O   = cts_q;
  assign COUNT_O = count_q;
  assign OVF_O   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_rx_fifo.sv
`default_nettype none
// ============================================================================
// tb_serial_rx_fifo : directed self-checking bench for serial_rx_fifo.
// Revision 1.0
// ============================================================================
module tb_serial_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] byte_i;
  logic       rdy_i;
  logic       rts_i;
  logic       tx_busy;
  logic [7:0] byte_o;
  logic       rdy_o;
  logic       cts_o;
  logic [4:0] count_o;
  logic       ovf_o;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0] got[$];
  int         got_cyc[$];

  int   busy_len   = 0;
  int   busy_cnt   = 0;
  logic busy_force = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  serial_rx_fifo dut (
    .CLK_100_I (clk),
    .RSTN_I    (rst_n),
    .BYTE_I    (byte_i),
    .RDY_I     (rdy_i),
    .RTS_I     (rts_i),
    .TX_BUSY_I (tx_busy),
    .BYTE_O    (byte_o),
    .RDY_O     (rdy_o),
    .CTS_O     (cts_o),
    .COUNT_O   (count_o),
    .OVF_O     (ovf_o)
  );

  initial begin
    forever begin
      @(negedge clk);
      if (rdy_o === 1'b1) begin
        got.push_back(byte_o);
        got_cyc.push_back(cyc);
      end
    end
  end

  // Transmitter model: goes busy for busy_len cycles after each strobe.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n !== 1'b1)                    busy_cnt = 0;
      else if (rdy_o === 1'b1 && busy_len > 0) busy_cnt = busy_len;
      else if (busy_cnt > 0)                 busy_cnt = busy_cnt - 1;
      tx_busy = busy_force || (busy_cnt > 0);
    end
  end

  task automatic push(input logic [7:0] b);
    byte_i = b;
    rdy_i  = 1'b1;
    @(negedge clk);
    rdy_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_got(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (got.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    idle(2);
    tests++; if (byte_o !== 8'h00) begin fails++; $display("FAIL rst_byte: got %02h, expected 00", byte_o); end
    tests++; if (rdy_o !== 1'b0)   begin fails++; $display("FAIL rst_rdy: got %b, expected 0", rdy_o); end
    tests++; if (cts_o !== 1'b1)   begin fails++; $display("FAIL rst_cts: got %b, expected 1", cts_o); end
    tests++; if (count_o !== 5'd0) begin fails++; $display("FAIL rst_count: got %0d, expected 0", count_o); end
    tests++; if (ovf_o !== 1'b0)   begin fails++; $display("FAIL rst_ovf: got %b, expected 0", ovf_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int t0;
    bit ok;
    busy_len = 10;
    idle(4);
    got.delete(); got_cyc.delete();
    t0 = cyc + 1;
    push(8'h41); push(8'h42); push(8'h43);
    wait_got(3, 100, ok);
    tests++; if (!ok) begin fails++; $display("FAIL basic_strobes: got %0d, expected 3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) begin
        tests++;
        if (got[i] !== 8'(8'h41 + i)) begin
          fails++; $display("FAIL basic_byte[%0d]: got %02h, expected %02h", i, got[i], 8'(8'h41 + i));
        end
      end
    end
    // push edge t0 -> strobe visible in the cycle after edge t0+1
    tests++;
    if (got_cyc.size() == 0 || got_cyc[0] != t0 + 1) begin
      fails++; $display("FAIL basic_latency: got cycle %0d, expected %0d", (got_cyc.size() > 0) ? got_cyc[0] : -1, t0 + 1);
    end
    tests++; if (count_o !== 5'd0) begin fails++; $display("FAIL basic_count: got %0d, expected 0", count_o); end
  endtask

  task automatic test_watermark;
    int prev;
    bit ok;
    idle(15);
    busy_len = 0;
    rts_i = 1'b0;
    idle(4);
    got.delete(); got_cyc.delete();
    for (int i = 0; i < 12; i++) begin
      push(8'(8'h80 + i));
      tests++; if (count_o !== 5'(i + 1)) begin fails++; $display("FAIL wm_fill_count[%0d]: got %0d, expected %0d", i, count_o, i + 1); end
      tests++; if (cts_o !== ((i + 1) < 12)) begin fails++; $display("FAIL wm_fill_cts[%0d]: got %b, expected %b", i, cts_o, ((i + 1) < 12)); end
    end
    rts_i = 1'b1;
    prev = 12;
    for (int c = 0; c < 200 && prev > 0; c++) begin
      @(negedge clk);
      #1;
      if (count_o != 5'(prev)) begin
        tests++; if (count_o !== 5'(prev - 1)) begin fails++; $display("FAIL wm_drain_count: got %0d, expected %0d", count_o, prev - 1); end
        tests++; if (cts_o !== ((prev - 1) <= 4)) begin fails++; $display("FAIL wm_drain_cts@%0d: got %b, expected %b", prev - 1, cts_o, ((prev - 1) <= 4)); end
        prev = prev - 1;
      end
    end
    tests++; if (prev != 0) begin fails++; $display("FAIL wm_drain_done: got count %0d, expected 0", count_o); end
    wait_got(12, 20, ok);
    tests++; if (!ok) begin fails++; $display("FAIL wm_strobes: got %0d, expected 12", got.size()); end
    for (int i = 0; i < 12; i++) begin
      if (i < got.size()) begin
        tests++;
        if (got[i] !== 8'(8'h80 + i)) begin fails++; $display("FAIL wm_byte[%0d]: got %02h, expected %02h", i, got[i], 8'(8'h80 + i)); end
      end
    end
  endtask

  task automatic test_overflow;
    bit ok;
    idle(10);
    busy_len = 0;
    rts_i = 1'b0;
    idle(4);
    got.delete(); got_cyc.delete();
    for (int i = 0; i < 16; i++) push(8'(i));
    tests++; if (count_o !== 5'd16) begin fails++; $display("FAIL ovf_count16: got %0d, expected 16", count_o); end
    tests++; if (ovf_o !== 1'b0)    begin fails++; $display("FAIL ovf_pre: got %b, expected 0", ovf_o); end
    push(8'h10);
    tests++; if (count_o !== 5'd16) begin fails++; $display("FAIL ovf_count17: got %0d, expected 16", count_o); end
    tests++; if (ovf_o !== 1'b1)    begin fails++; $display("FAIL ovf_set: got %b, expected 1", ovf_o); end
    tests++; if (cts_o !== 1'b0)    begin fails++; $display("FAIL ovf_cts: got %b, expected 0", cts_o); end
    rts_i = 1'b1;
    wait_got(16, 200, ok);
    idle(20);
    tests++; if (got.size() != 16) begin fails++; $display("FAIL ovf_strobes: got %0d, expected 16", got.size()); end
    for (int i = 0; i < 16; i++) begin
      if (i < got.size()) begin
        tests++;
        if (got[i] !== 8'(i)) begin fails++; $display("FAIL ovf_byte[%0d]: got %02h, expected %02h", i, got[i], 8'(i)); end
      end
    end
    tests++; if (ovf_o !== 1'b1)   begin fails++; $display("FAIL ovf_sticky: got %b, expected 1", ovf_o); end
    tests++; if (count_o !== 5'd0) begin fails++; $display("FAIL ovf_drained: got %0d, expected 0", count_o); end
  endtask

  task automatic test_full_pushpop;
    bit ok;
    busy_len   = 0;
    busy_force = 1'b1;
    rts_i      = 1'b1;
    do_reset;
    idle(3);
    got.delete(); got_cyc.delete();
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    tests++; if (count_o !== 5'd16) begin fails++; $display("FAIL fpp_fill: got %0d, expected 16", count_o); end
    tests++; if (got.size() != 0)   begin fails++; $display("FAIL fpp_held: got %0d strobes, expected 0", got.size()); end
    busy_force = 1'b0;
    @(negedge clk);
    push(8'hAA);
    tests++; if (count_o !== 5'd16) begin fails++; $display("FAIL fpp_count: got %0d, expected 16", count_o); end
    tests++; if (ovf_o !== 1'b0)    begin fails++; $display("FAIL fpp_ovf: got %b, expected 0", ovf_o); end
    wait_got(17, 120, ok);
    tests++; if (!ok) begin fails++; $display("FAIL fpp_strobes: got %0d, expected 17", got.size()); end
    for (int i = 0; i < 17; i++) begin
      if (i < got.size()) begin
        tests++;
        if (got[i] !== ((i < 16) ? 8'(8'h20 + i) : 8'hAA)) begin
          fails++; $display("FAIL fpp_byte[%0d]: got %02h, expected %02h", i, got[i], (i < 16) ? 8'(8'h20 + i) : 8'hAA);
        end
      end
    end
  endtask

  task automatic test_reset_gap;
    int t0;
    bit ok;
    busy_len   = 10;
    busy_force = 1'b1;
    rts_i      = 1'b1;
    do_reset;
    idle(3);
    got.delete(); got_cyc.delete();
    for (int i = 0; i < 6; i++) push(8'(8'h60 + i));
    busy_force = 1'b0;
    wait_got(1, 20, ok);
    tests++; if (!ok) begin fails++; $display("FAIL gap_first_strobe: got %0d, expected 1", got.size()); end
    @(negedge clk);
    tests++; if (count_o !== 5'd5) begin fails++; $display("FAIL gap_count: got %0d, expected 5", count_o); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (byte_o !== 8'h00) begin fails++; $display("FAIL gap_rst_byte: got %02h, expected 00", byte_o); end
    tests++; if (rdy_o !== 1'b0)   begin fails++; $display("FAIL gap_rst_rdy: got %b, expected 0", rdy_o); end
    tests++; if (cts_o !== 1'b1)   begin fails++; $display("FAIL gap_rst_cts: got %b, expected 1", cts_o); end
    tests++; if (count_o !== 5'd0) begin fails++; $display("FAIL gap_rst_count: got %0d, expected 0", count_o); end
    tests++; if (ovf_o !== 1'b0)   begin fails++; $display("FAIL gap_rst_ovf: got %b, expected 0", ovf_o); end
    idle(2);
    rst_n    = 1'b1;
    busy_len = 0;
    idle(3);
    got.delete(); got_cyc.delete();
    t0 = cyc + 1;
    push(8'h55);
    wait_got(1, 20, ok);
    tests++; if (!ok || got[0] !== 8'h55) begin fails++; $display("FAIL gap_post_byte: got %0d strobes, expected one 55", got.size()); end
    tests++;
    if (got_cyc.size() == 0 || got_cyc[0] != t0 + 1) begin
      fails++; $display("FAIL gap_post_latency: got cycle %0d, expected %0d", (got_cyc.size() > 0) ? got_cyc[0] : -1, t0 + 1);
    end
  endtask

  task automatic test_wrap;
    bit ok;
    busy_len = 0;
    idle(5);
    got.delete(); got_cyc.delete();
    for (int i = 0; i < 40; i++) begin
      push(8'(8'hC0 + i));
      idle(1);
    end
    wait_got(40, 300, ok);
    tests++; if (!ok) begin fails++; $display("FAIL wrap_strobes: got %0d, expected 40", got.size()); end
    for (int i = 0; i < 40; i++) begin
      if (i < got.size()) begin
        tests++;
        if (got[i] !== 8'(8'hC0 + i)) begin fails++; $display("FAIL wrap_byte[%0d]: got %02h, expected %02h", i, got[i], 8'(8'hC0 + i)); end
      end
    end
    tests++; if (ovf_o !== 1'b0) begin fails++; $display("FAIL wrap_ovf: got %b, expected 0", ovf_o); end
  endtask

  initial begin
    rst_n  = 1'b0;
    byte_i = 8'h00;
    rdy_i  = 1'b0;
    rts_i  = 1'b1;
    test_reset;
    test_basic;
    test_watermark;
    test_overflow;
    test_full_pushpop;
    test_reset_gap;
    test_wrap;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_rx_fifo.md
SERIAL_RX_FIFO -- requirements
Module: serial_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, 4..256.
REQ-002 Parameter HI_WM, default 12, fill level at or above which CTS_O SHALL deassert.
REQ-003 Parameter LO_WM, default 4, fill level at or below which CTS_O SHALL reassert; SHALL be less than HI_WM.
REQ-004 CLK_100_I  in  1  the single 100 MHz clock; all logic SHALL be rising-edge clocked on it.
REQ-005 RSTN_I  in  1  reset, asynchronous and active-low.
REQ-006 BYTE_I  in  8  received byte from the UART receiver.
REQ-007 RDY_I  in  1  one-cycle strobe; BYTE_I is valid while it is high.
REQ-008 RTS_I  in  1  host ready-to-receive; asynchronous pin.
REQ-009 TX_BUSY_I  in  1  transmitter busy; SHALL rise within 1 cycle of RDY_O.
REQ-010 BYTE_O  out  8  byte to the transmitter.
REQ-011 RDY_O  out  1  one-cycle strobe to the transmitter; BYTE_O is valid while it is high.
REQ-012 CTS_O  out  1  clear-to-send to the host; 1 means the host may send.
REQ-013 COUNT_O  out  log2(DEPTH)+1  current fill level.
REQ-014 OVF_O  out  1  sticky overflow flag.

Function
REQ-015 Push: RDY_I=1 with count<DEPTH SHALL write BYTE_I at the write pointer and increment count on the same edge.
REQ-016 Push while count==DEPTH and no pop in that cycle SHALL drop the byte, leave count and pointers unchanged, and set OVF_O.
REQ-017 Push and pop on the same edge SHALL leave count unchanged, including at count==DEPTH; OVF_O SHALL stay unchanged.
REQ-018 Pointers SHALL wrap modulo DEPTH; full and empty SHALL be derived from count, never from pointer equality alone.
REQ-019 RTS_I SHALL pass through a 2-flop synchronizer; rts_s below means the synchronized value.
REQ-020 The read FSM SHALL have three states: IDLE, LOAD, GAP.
REQ-021 IDLE -> LOAD when count!=0, rts_s=1 and TX_BUSY_I=0; the pop (register BYTE_O, advance the read pointer) SHALL occur on that edge.
REQ-022 In LOAD, RDY_O SHALL be 1 for exactly one cycle; LOAD -> GAP unconditionally.
REQ-023 In GAP, the FSM SHALL remain at least one cycle, then go to IDLE on the first cycle with TX_BUSY_I=0.
REQ-024 Byte-to-RDY_O latency SHALL be 2 cycles minimum: a push at edge N into an empty, idle FIFO gives RDY_O=1 in the cycle after edge N+1.
REQ-025 BYTE_O SHALL hold its value outside LOAD.
REQ-026 CTS_O SHALL be a registered hysteresis flag: clear when count>=HI_WM, set when count<=LO_WM, otherwise held.
REQ-027 rts_s falling while the FSM is in LOAD or GAP SHALL NOT abort the byte in flight; only new pops SHALL be blocked.
REQ-028 Bytes SHALL leave in arrival order with no duplication or loss except under REQ-016.

Reset
REQ-029 Asserting RSTN_I low SHALL immediately clear pointers, count and the synchronizer, and set the FSM to IDLE, regardless of the current state.
REQ-030 During reset, outputs SHALL be: BYTE_O=0x00, RDY_O=0, CTS_O=1, COUNT_O=0, OVF_O=0.
REQ-031 Reset deassertion is synchronous to CLK_100_I (handled externally); storage contents need not be cleared.
REQ-032 OVF_O SHALL be cleared only by reset.

Structure
REQ-033 Package serial_pkg SHALL hold: the data width (8), DEPTH/HI_WM/LO_WM defaults, and the read-FSM state enumeration.
REQ-034 The synchronizer SHALL be the sub-module serial_sync2 (2-flop, async active-low reset, reset value 0).
REQ-035 Storage SHALL be an inferred register array with a synchronous write; no vendor primitives.

Verification
REQ-036 Reset, then 3 pushes 0x41,0x42,0x43 with rts_s=1, TX_BUSY_I high for 10 cycles after each RDY_O -> 3 RDY_O strobes carrying 0x41,0x42,0x43 in order; first strobe 2 cycles after the first push.
REQ-037 RTS_I=0, push 12 bytes -> CTS_O=0 on the edge count reaches 12; RTS_I=1, drain -> CTS_O=1 on the edge count reaches 4; COUNT_O tracks every step.
REQ-038 RTS_I=0, push 17 bytes 0x00..0x10 -> COUNT_O=16, OVF_O=1, 0x10 dropped; after RTS_I=1, output is exactly 0x00..0x0F.
REQ-039 count=16, push 0xAA on the same edge as the IDLE->LOAD pop -> COUNT_O stays 16, OVF_O=0, 0xAA is emitted last.
REQ-040 RSTN_I pulsed low during GAP with count=5 -> all outputs at reset values immediately; next push 0x55 emitted with 2-cycle latency.
REQ-041 Pointer wrap: 40 bytes streamed with a push/pop interleave -> all 40 bytes emitted in order, OVF_O=0.
